alu_reduce_accum: RTL and testbench

- Downstream consumer of the ALU result stream.
- Folds a packet of 32-bit ALU results into one scalar: wrapping sum, unsigned minimum, or count of EQ flags.
- Presents the scalar to the writeback/host side with a valid/ready handshake.
- Used for dot-product, vector-min and compare-count kernels on the maths accelerator.

---
 rtl/alu_reduce_accum_pkg.sv | 16 +
 rtl/alu_reduce_step.sv | 34 +++
 rtl/alu_reduce_accum.sv | 76 +++++++
 tb/tb_alu_reduce_accum.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_reduce_accum_pkg.sv
// alu_reduce_accum_pkg: shared reduction modes, FSM states and default widths
// Optional feature macro used by this slice: ALU_REDUCE_SAT_EN (saturating RED_SUM)
package alu_reduce_accum_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    typedef enum logic [1:0] {
        RED_SUM   = 2'd0,
        RED_MIN   = 2'd1,
        RED_EQCNT = 2'd2
    } red_mode_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } red_state_t;
endpackage

// File: rtl/alu_reduce_step.sv
// alu_reduce_step: one combinational reduction step (acc, data, eq, mode -> next_acc, carry)
// Ports: acc/data are the running value and the new ALU result, eq the ALU EQ flag,
// mode the reduction select (2'd3 treated as sum); carry flags a sum carry-out.
// Macro ALU_REDUCE_SAT_EN: sum clamps to all-ones on carry instead of wrapping.
module alu_reduce_step
    import alu_reduce_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data,
    input  logic              eq,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] next_acc,
    output logic              carry
);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] eq_ext;
    logic [DATA_W-1:0] sum_val;
    logic              is_sum;
    assign sum    = {1'b0, acc} + {1'b0, data};
    assign eq_ext = {{(DATA_W-1){1'b0}}, eq};
    assign is_sum = (mode != RED_MIN) && (mode != RED_EQCNT);
`ifdef ALU_REDUCE_SAT_EN
    assign sum_val = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
    assign sum_val = sum[DATA_W-1:0];
`endif
    always_comb begin
        carry    = is_sum && sum[DATA_W];
        next_acc = (mode == RED_MIN)   ? ((data < acc) ? data : acc) :
                   (mode == RED_EQCNT) ? acc + eq_ext : sum_val;
    end
endmodule

// File: rtl/alu_reduce_accum.sv
// alu_reduce_accum: folds a packet of ALU results into one sum / unsigned min / EQ count
// Ports: in_* is the ALU result beat stream (valid/ready, in_last ends a packet, mode
// sampled on the first beat); out_* presents data, beat count and sticky overflow with
// valid/ready; busy is high while a packet is open or a result is pending.
// Macro ALU_REDUCE_SAT_EN: saturating sum (handled in alu_reduce_step).
module alu_reduce_accum
    import alu_reduce_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_eq,
    input  logic              in_last,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);
    red_state_t        state, state_n;
    logic [DATA_W-1:0] acc, step_acc, step_in;
    logic [CNT_W-1:0]  count;
    logic [1:0]        mode_q, step_mode;
    logic              ovf, carry, accept, idle;
    assign idle   = state == IDLE;
    assign accept = in_valid && in_ready;
    // First beat folds into the identity of the incoming mode so the step logic is shared.
    assign step_mode = idle ? mode : mode_q;
    assign step_in   = idle ? ((mode == RED_MIN) ? '1 : '0) : acc;
    alu_reduce_step #(.DATA_W(DATA_W)) u_step (
        .acc      (step_in),
        .data     (in_data),
        .eq       (in_eq),
        .mode     (step_mode),
        .next_acc (step_acc),
        .carry    (carry)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n   = state;
        in_ready  = state != DONE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        case (state)
            IDLE, ACCUM: state_n = accept ? (in_last ? DONE : ACCUM) : state;
            DONE:        state_n = out_ready ? IDLE : DONE;
            default:     state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            count  <= '0;
            mode_q <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            acc    <= step_acc;
            mode_q <= step_mode;
            count  <= idle ? CNT_W'(1) : (&count ? count : count + CNT_W'(1));
            ovf    <= !idle && (ovf || carry || &count);
        end
    end
    assign out_data  = acc;
    assign out_count = count;
    assign out_ovf   = ovf;
endmodule

// File: tb/tb_alu_reduce_accum.sv
// tb_alu_reduce_accum: directed packets with a scoreboard queue checked by a result monitor
module tb_alu_reduce_accum;
    import alu_reduce_accum_pkg::*;
    localparam int DW = 32;
    localparam int CW = 4;
`ifdef ALU_REDUCE_SAT_EN
    localparam logic [DW-1:0] SUM_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [DW-1:0] SUM_EXP = 32'h0000_0004;
`endif
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          o;
    } exp_t;
    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_eq = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    mode = 2'd0;
    logic          in_ready, out_valid, out_ovf, busy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0, errors = 0;
    always #5 clk = ~clk;
    alu_reduce_accum #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_eq     (in_eq),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );
    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask
    task automatic send(input logic [DW-1:0] d, input logic e, input logic l, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_eq    = e;
        in_last  = l;
        mode     = m;
        for (int n = 0; n < 50 && !in_ready; n++) begin
            @(posedge clk);
            #1;
        end
        if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask
    task automatic wait_idle();
        for (int n = 0; n < 50 && busy; n++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'b0, busy}, 0);
    endtask
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", out_data, 32'hDEAD_BEEF ^ out_data ^ out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e.d);
                chk("out_count", DW'(out_count), DW'(mon_e.c));
                chk("out_ovf", {31'b0, out_ovf}, {31'b0, mon_e.o});
            end
        end
    end
    initial begin
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", DW'(out_count), 0);
        chk("rst_out_ovf", {31'b0, out_ovf}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        // wrapping sum with carry-out: 5 + 7 + 0xFFFFFFF8 = 0x1_00000004
        exp_q.push_back('{SUM_EXP, 4'd3, 1'b1});
        send(32'd5, 1'b0, 1'b0, RED_SUM);
        send(32'd7, 1'b0, 1'b0, RED_SUM);
        send(32'hFFFF_FFF8, 1'b0, 1'b1, RED_SUM);
        wait_idle();
        // unsigned min with latency check
        exp_q.push_back('{32'd3, 4'd3, 1'b0});
        send(32'h8000_0000, 1'b0, 1'b0, RED_MIN);
        send(32'd3, 1'b0, 1'b0, RED_MIN);
        chk("min_valid_before_last", {31'b0, out_valid}, 0);
        send(32'd9, 1'b0, 1'b1, RED_MIN);
        chk("min_valid_after_last", {31'b0, out_valid}, 1);
        wait_idle();
        // EQ count with idle gaps between beats
        exp_q.push_back('{32'd3, 4'd4, 1'b0});
        send(32'h1234, 1'b1, 1'b0, RED_EQCNT);
        repeat (2) begin @(posedge clk); #1; end
        send(32'h0, 1'b0, 1'b0, RED_SUM);
        repeat (3) begin @(posedge clk); #1; end
        send(32'hFFFF, 1'b1, 1'b0, RED_MIN);
        @(posedge clk);
        #1;
        send(32'h7, 1'b1, 1'b1, RED_SUM);
        wait_idle();
        // backpressure: result held, following beat waits for the bubble
        exp_q.push_back('{32'h11, 4'd1, 1'b0});
        exp_q.push_back('{32'h22, 4'd1, 1'b0});
        out_ready = 1'b0;
        send(32'h11, 1'b0, 1'b1, RED_SUM);
        in_valid = 1'b1;
        in_data  = 32'h22;
        in_last  = 1'b1;
        mode     = RED_SUM;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_out_data", out_data, 32'h11);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_valid", {31'b0, out_valid}, 0);
        chk("bp_idle_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", {31'b0, out_valid}, 1);
        chk("bp_next_data", out_data, 32'h22);
        wait_idle();
        // mode input ignored after the first beat
        exp_q.push_back('{32'd4, 4'd3, 1'b0});
        send(32'd2, 1'b0, 1'b0, RED_SUM);
        send(32'd1, 1'b0, 1'b0, RED_MIN);
        send(32'd1, 1'b0, 1'b1, RED_MIN);
        wait_idle();
        // count boundary: 15 beats fills the counter, 17 saturates it
        exp_q.push_back('{32'd15, 4'd15, 1'b0});
        for (int i = 0; i < 15; i++) send(DW'(i), 1'b1, i == 14, RED_EQCNT);
        wait_idle();
        exp_q.push_back('{32'd17, 4'd15, 1'b1});
        for (int i = 0; i < 17; i++) send(DW'(i), 1'b1, i == 16, RED_EQCNT);
        wait_idle();
        // async reset mid-packet discards the partial result
        send(32'h55, 1'b0, 1'b0, RED_SUM);
        send(32'h66, 1'b0, 1'b0, RED_SUM);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_out_count", DW'(out_count), 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_after_valid", {31'b0, out_valid}, 0);
        exp_q.push_back('{32'h10, 4'd1, 1'b0});
        send(32'h10, 1'b0, 1'b1, RED_SUM);
        wait_idle();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        chk("queue_drained", DW'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
